regbank_wb_arbiter: RTL

Write-back arbiter for the register bank's single write port. It shares that port between two producers: the ALU write-back stage and the load (MEM) write-back stage. Each cycle it grants at most one requester on a valid/ready handshake, using round-robin order. The accepted write is registered onto the bank's AdrC/C/W inputs for exactly one cycle. It sits between the pipeline's write-back stages and the register bank, and is the only driver of the bank's write port.

---
 rtl/regbank_pkg.sv | 17 +
 rtl/regbank_wb_arbiter_if.sv | 36 +++
 rtl/rr_arb2.sv | 23 ++
 rtl/regbank_wb_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants for the register-bank write-back path.
package regbank_pkg;

  localparam int unsigned ADR_W_DEF  = 5;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [ADR_W_DEF-1:0] REG_ZERO = '0;

  // Source encoding reported on gnt_id
  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  // Round-robin preference state
  localparam logic [0:0] PREF_ALU = 1'b0;
  localparam logic [0:0] PREF_MEM = 1'b1;

endpackage

// File: rtl/regbank_wb_arbiter_if.sv
// Write-back producers <-> arbiter <-> register bank write port bundle.
interface regbank_wb_arbiter_if
  import regbank_pkg::*;
#(
  parameter int unsigned ADR_W  = ADR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              alu_valid;
  logic [ADR_W-1:0]  alu_adr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic [ADR_W-1:0]  AdrC;
  logic [DATA_W-1:0] C;
  logic              W;
  logic              gnt_id;

  // Producer / observer side
  modport master (
    output alu_valid, alu_adr, alu_data, mem_valid, mem_adr, mem_data,
    input  alu_ready, mem_ready, AdrC, C, W, gnt_id
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_adr, alu_data, mem_valid, mem_adr, mem_data,
    output alu_ready, mem_ready, AdrC, C, W, gnt_id
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot grant, preferred side wins a tie.
module rr_arb2
  import regbank_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [0:0] i_pref,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // Grant: nothing when disabled, sole requester wins, else preferred side
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_gnt = (i_pref == PREF_MEM) ? 2'b10 : 2'b01;
      end else begin
        o_gnt = i_req;
      end
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Arbitrates ALU and MEM write-back onto the register bank's single write port.
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned ADR_W     = ADR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter bit          ZERO_DROP = 1'b1
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 hold,
  regbank_wb_arbiter_if.slave  bus
);

  logic [0:0]        r_pref;
  logic [ADR_W-1:0]  r_adr;
  logic [DATA_W-1:0] r_data;
  logic              r_w;
  logic              r_gnt_id;

  logic              w_en;
  logic [1:0]        w_gnt;
  logic              w_xfer;
  logic              w_sel_mem;
  logic [ADR_W-1:0]  w_adr;
  logic [DATA_W-1:0] w_data;
  logic              w_drop;

  // Reset also blocks grants so a request in the reset cycle is never taken
  assign w_en = ~hold & ~R;

  rr_arb2 u_rr_arb2 (
    .i_req  ({bus.mem_valid, bus.alu_valid}),
    .i_pref (r_pref),
    .i_en   (w_en),
    .o_gnt  (w_gnt)
  );

  assign bus.alu_ready = w_gnt[0];
  assign bus.mem_ready = w_gnt[1];

  // Grant only ever goes to a valid requester, so any grant is a transfer
  assign w_xfer    = |w_gnt;
  assign w_sel_mem = w_gnt[1];

  // Select winner's address and data
  always_comb begin
    w_adr  = bus.alu_adr;
    w_data = bus.alu_data;
    if (w_sel_mem) begin
      w_adr  = bus.mem_adr;
      w_data = bus.mem_data;
    end
  end

  assign w_drop = ZERO_DROP && (w_adr == REG_ZERO);

  // Preference flips to the other side after every transfer, frozen otherwise
  always_ff @(posedge clk) begin
    if (R) begin
      r_pref <= PREF_ALU;
    end else if (w_xfer) begin
      r_pref <= w_sel_mem ? PREF_ALU : PREF_MEM;
    end
  end

  // Output register: load winner, strike W for one cycle unless the target is r0
  always_ff @(posedge clk) begin
    if (R) begin
      r_adr    <= '0;
      r_data   <= '0;
      r_w      <= 1'b0;
      r_gnt_id <= GNT_ALU;
    end else if (w_xfer) begin
      r_adr    <= w_adr;
      r_data   <= w_data;
      r_w      <= ~w_drop;
      r_gnt_id <= w_sel_mem ? GNT_MEM : GNT_ALU;
    end else begin
      r_w      <= 1'b0;
    end
  end

  assign bus.AdrC   = r_adr;
  assign bus.C      = r_data;
  assign bus.W      = r_w;
  assign bus.gnt_id = r_gnt_id;

endmodule
